// File: rtl/program_loader_if.sv
// Fetch/load bus between the board-side program source and the loader.
// master = program source + processor side, slave = program_loader.
interface program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              load_start;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic              load_done;
    logic              run_start;
    logic              run_stop;
    logic [ADDR_W-1:0] pc_addr;
    logic [DATA_W-1:0] instruction;
    logic              cpu_run;
    logic              halted;
    logic [ADDR_W:0]   prog_len;
    logic              overflow;

    modport master (
        output load_start, load_data, load_valid, load_done, run_start, run_stop, pc_addr,
        input  load_ready, instruction, cpu_run, halted, prog_len, overflow
    );

    modport slave (
        input  load_start, load_data, load_valid, load_done, run_start, run_stop, pc_addr,
        output load_ready, instruction, cpu_run, halted, prog_len, overflow
    );
endinterface

// File: rtl/program_loader.sv
// Instruction RAM filled over a valid/ready byte stream, then served to a
// single-cycle core through an asynchronous read while the run FSM allows it.
module program_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic             clk,
    input  logic             RST,
    program_loader_if.slave  bus
);
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} stateT;

    stateT             state, nextState;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   progLen;
    logic              overflowQ;
    logic              clrSession, doWrite, setOverflow;
    logic              notFull, pastEnd;

    assign notFull = progLen < FULL_LEN;
    assign pastEnd = {1'b0, bus.pc_addr} >= progLen;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState       = state;
        clrSession      = 1'b0;
        doWrite         = 1'b0;
        setOverflow     = 1'b0;
        bus.load_ready  = 1'b0;
        bus.cpu_run     = 1'b0;
        bus.halted      = 1'b0;
        bus.instruction = '0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    nextState  = LOAD;
                    clrSession = 1'b1;
                end else if (bus.run_start && progLen != '0) begin
                    nextState = RUN;
                end
            end
            LOAD: begin
                bus.load_ready = notFull;
                // A restart drops whatever byte is offered on the same edge.
                if (bus.load_start) begin
                    clrSession = 1'b1;
                end else begin
                    doWrite     = bus.load_valid && notFull;
                    setOverflow = bus.load_valid && !notFull;
                    if (bus.load_done) nextState = IDLE;
                end
            end
            RUN: begin
                bus.cpu_run = 1'b1;
                if (!pastEnd) bus.instruction = mem[bus.pc_addr[IDX_W-1:0]];
                if (bus.run_stop)  nextState = IDLE;
                else if (pastEnd)  nextState = HALT;
            end
            HALT: begin
                bus.halted = 1'b1;
                if (bus.load_start) begin
                    nextState  = LOAD;
                    clrSession = 1'b1;
                end else if (bus.run_start) begin
                    nextState = RUN;
                end else if (bus.run_stop) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // progLen doubles as the write pointer: bytes land strictly in order.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            progLen   <= '0;
            overflowQ <= 1'b0;
        end else if (clrSession) begin
            progLen   <= '0;
            overflowQ <= 1'b0;
        end else begin
            if (doWrite)     progLen   <= progLen + 1'b1;
            if (setOverflow) overflowQ <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) mem[progLen[IDX_W-1:0]] <= bus.load_data;
    end

    assign bus.prog_len = progLen;
    assign bus.overflow = overflowQ;
endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader against a session-level
// reference model (program array, length, overflow flag, run mode).
module tb_program_loader;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int passCnt  = 0;
    int checkCnt = 0;

    int         mMode;
    int         mLen;
    bit         mOvf;
    logic [7:0] mMem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic modelReset();
        mMode = M_IDLE;
        mLen  = 0;
        mOvf  = 1'b0;
    endtask

    task automatic checkOutputs();
        logic [7:0] expInst;
        expInst = 8'h00;
        if (mMode == M_RUN && int'(bus.pc_addr) < mLen) expInst = mMem[bus.pc_addr];
        chk("load_ready", bus.load_ready, (mMode == M_LOAD && mLen < DEPTH) ? 1 : 0);
        chk("cpu_run", bus.cpu_run, (mMode == M_RUN) ? 1 : 0);
        chk("halted", bus.halted, (mMode == M_HALT) ? 1 : 0);
        chk("instruction", bus.instruction, expInst);
        chk("prog_len", bus.prog_len, mLen);
        chk("overflow", bus.overflow, mOvf);
    endtask

    // Session semantics applied at a clock edge from the inputs presented.
    task automatic modelEdge();
        case (mMode)
            M_IDLE: begin
                if (bus.load_start) begin
                    mMode = M_LOAD; mLen = 0; mOvf = 1'b0;
                end else if (bus.run_start && mLen != 0) begin
                    mMode = M_RUN;
                end
            end
            M_LOAD: begin
                if (bus.load_start) begin
                    mLen = 0; mOvf = 1'b0;
                end else begin
                    if (bus.load_valid) begin
                        if (mLen < DEPTH) begin
                            mMem[mLen] = bus.load_data;
                            mLen++;
                        end else begin
                            mOvf = 1'b1;
                        end
                    end
                    if (bus.load_done) mMode = M_IDLE;
                end
            end
            M_RUN: begin
                if (bus.run_stop) mMode = M_IDLE;
                else if (int'(bus.pc_addr) >= mLen) mMode = M_HALT;
            end
            default: begin
                if (bus.load_start) begin
                    mMode = M_LOAD; mLen = 0; mOvf = 1'b0;
                end else if (bus.run_start) begin
                    mMode = M_RUN;
                end else if (bus.run_stop) begin
                    mMode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        checkOutputs();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic drive(input bit ls, input bit ld, input bit lv, input logic [7:0] d,
                         input bit rs, input bit stop, input logic [7:0] pc);
        bus.load_start = ls;
        bus.load_done  = ld;
        bus.load_valid = lv;
        bus.load_data  = d;
        bus.run_start  = rs;
        bus.run_stop   = stop;
        bus.pc_addr    = pc;
        step();
    endtask

    task automatic clearInputs();
        bus.load_start = 1'b0;
        bus.load_done  = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.run_start  = 1'b0;
        bus.run_stop   = 1'b0;
        bus.pc_addr    = '0;
    endtask

    initial begin
        logic [7:0] prog [4];
        prog[0] = 8'h41; prog[1] = 8'h52; prog[2] = 8'hC1; prog[3] = 8'h00;
        for (int i = 0; i < DEPTH; i++) mMem[i] = 8'h00;
        clearInputs();
        RST = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.load_ready, 0);
        chk("rst_cpu_run", bus.cpu_run, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_instr", bus.instruction, 0);
        chk("rst_len", bus.prog_len, 0);
        chk("rst_ovf", bus.overflow, 0);
        @(negedge clk);
        RST = 1'b0;
        @(posedge clk);
        #1;

        // Basic 4-byte load and run to the end of the program.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, prog[i], 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("load4_len", bus.prog_len, 4);
        chk("load4_ready", bus.load_ready, 0);
        chk("load4_ovf", bus.overflow, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 8'(i));
        drive(0, 0, 0, 0, 0, 0, 8'd4);
        chk("halt_flag", bus.halted, 1);
        chk("halt_run", bus.cpu_run, 0);
        drive(0, 0, 0, 0, 0, 0, 8'd4);

        // Fill the RAM, then offer one extra byte.
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, 8'(i), 0, 0, 0);
        chk("full_ready", bus.load_ready, 0);
        drive(0, 0, 1, 8'hAA, 0, 0, 0);
        chk("full_ovf", bus.overflow, 1);
        chk("full_len", bus.prog_len, DEPTH);
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 8'd0);
        chk("full_mem0", bus.instruction, 8'h00);
        drive(0, 0, 0, 0, 0, 1, 8'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("reload_ovf", bus.overflow, 0);

        // Last byte accompanied by load_done.
        drive(0, 0, 1, 8'h11, 0, 0, 0);
        drive(0, 0, 1, 8'h22, 0, 0, 0);
        drive(0, 1, 1, 8'h33, 0, 0, 0);
        chk("done_len", bus.prog_len, 3);
        chk("done_ready", bus.load_ready, 0);

        // Asynchronous reset while running at pc=2.
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 8'd0);
        drive(0, 0, 0, 0, 0, 0, 8'd1);
        bus.pc_addr = 8'd2;
        #2;
        chk("pre_rst_instr", bus.instruction, 8'h33);
        RST = 1'b1;
        modelReset();
        #1;
        chk("arst_run", bus.cpu_run, 0);
        chk("arst_instr", bus.instruction, 0);
        chk("arst_len", bus.prog_len, 0);
        @(negedge clk);
        RST = 1'b0;
        clearInputs();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("norun_empty", bus.cpu_run, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // load_start beats run_start; run_stop beats halt detection.
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("ls_wins_run", bus.cpu_run, 0);
        chk("ls_wins_ready", bus.load_ready, 1);
        drive(0, 0, 1, 8'h5A, 0, 0, 0);
        drive(0, 1, 1, 8'hA5, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 8'd5);
        chk("stop_halted", bus.halted, 0);
        chk("stop_run", bus.cpu_run, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int pcMax;
            pcMax = (mLen + 2 > 255) ? 255 : mLen + 2;
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 1) == 1, 8'($urandom),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0,
                  8'($urandom_range(0, pcMax)));
        end
        step();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Program-side counterpart of the 8-bit processor's fetch interface.
- Gives the processor its `instruction[7:0]` byte for the processor's `PCOutput` address.
- Holds a DEPTH x 8 instruction RAM that is filled over a valid/ready byte-load handshake while the core is stopped.
- Then gates execution through a run/halt state machine.
- Sits between the board-level program source (switches/UART shim) and the processor top.

Parameters:
- DEPTH, 256, instruction RAM entries; power of two, at most 2**ADDR_W.
- ADDR_W, 8, address width; matches the processor PC width.
- DATA_W, 8, instruction width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- load_start  input  1  pulse; opens a load session.
- load_data  input  DATA_W  instruction byte to store.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  loader accepts a byte this cycle.
- load_done  input  1  pulse; closes the load session.
- run_start  input  1  pulse; starts execution.
- run_stop  input  1  pulse; aborts execution.
- pc_addr  input  ADDR_W  fetch address; driven from the processor PC.
- instruction  output  DATA_W  fetched instruction; drives the processor instruction input.
- cpu_run  output  1  processor may advance (clock enable / reset release).
- halted  output  1  program ran off its end.
- prog_len  output  ADDR_W+1  number of bytes loaded, 0..DEPTH.
- overflow  output  1  sticky; a byte was offered while the RAM was full.

Behaviour:
- States: IDLE, LOAD, RUN, HALT, encoded in a state register.
- Reset (asynchronous, RST=1):
  - state=IDLE, write pointer=0, prog_len=0, overflow=0.
  - load_ready=0, cpu_run=0, halted=0, instruction=0.
  - RAM contents are not cleared.
- IDLE:
  - load_start=1 -> LOAD; write pointer, prog_len and overflow cleared on that edge.
  - run_start=1 with prog_len!=0 -> RUN.
  - run_start with prog_len==0 is ignored.
  - load_start and run_start together: load_start wins.
- LOAD:
  - load_ready = (prog_len < DEPTH), combinational from registered state.
  - Transfer occurs when load_valid && load_ready: mem[wptr] <= load_data, wptr++, prog_len++.
  - One byte per cycle max; zero-latency acceptance.
  - Full (prog_len==DEPTH): load_ready=0; load_valid=1 sets overflow (sticky until next load_start or RST); data is dropped, no wrap.
  - load_done=1 -> IDLE. A transfer in the same cycle is still written. load_ready is 0 from the next cycle.
  - load_start in LOAD restarts the session: pointer, prog_len and overflow cleared; a same-cycle transfer is discarded.
  - run_start in LOAD is ignored.
- RUN:
  - cpu_run=1.
  - instruction = mem[pc_addr], asynchronous read, same cycle. This is required because the core is single-cycle.
  - If pc_addr >= prog_len, instruction=0 and the state goes to HALT on the next edge.
  - run_stop=1 -> IDLE; takes priority over halt detection.
  - load_start in RUN is ignored.
- HALT:
  - cpu_run=0, halted=1, instruction=0.
  - run_start -> RUN; the processor must be reset by the top level so PC=0.
  - load_start -> LOAD; run_stop -> IDLE; load_start has priority.
- Outside RUN, instruction=0 and cpu_run=0.
- prog_len width is ADDR_W+1, so DEPTH itself is representable. The comparison pc_addr >= prog_len is an unsigned compare with pc_addr zero-extended.
- RST mid-LOAD or mid-RUN: immediate return to IDLE. Partially loaded bytes remain in RAM but prog_len=0, so the program must be reloaded.
- No combinational path from load_valid to load_ready.

Test Plan:
- Reset then load 4 bytes 0x41,0x52,0xC1,0x00 with load_valid held high, then load_done:
  - load_ready=1 for 4 cycles; prog_len=4; state IDLE; overflow=0.
- After load, run_start:
  - cpu_run=1.
  - pc_addr=0..3 -> instruction 0x41,0x52,0xC1,0x00 in the same cycle.
  - pc_addr=4 -> instruction=0, next cycle halted=1, cpu_run=0.
- Fill DEPTH bytes (value = index), then offer one more:
  - load_ready=0 at prog_len=256; overflow=1; mem[0] still 0x00.
  - After reload start, overflow=0.
- load_valid with load_done in the same cycle on byte 3 -> byte stored, prog_len=3, then IDLE with load_ready=0.
- Assert RST mid-RUN at pc_addr=2 -> cpu_run=0 and instruction=0 asynchronously; prog_len=0; run_start is then ignored until a reload.
- Simultaneous load_start+run_start in IDLE -> LOAD entered, cpu_run stays 0; run_stop in RUN at pc_addr>=prog_len -> IDLE, halted stays 0.
